helix_loom_feedback_tx: RTL

Loom-side transmitter that produces the feedback_valid/feedback_delta stream consumed by the Reservoir's latent-potential update.
- Accepts Loom observation vectors over a valid/ready handshake.
- Folds each observation's change versus the previous observation into a FEEDBACK_W delta and queues it.
- Issues deltas as single-cycle pulses. The feedback interface has no ready, so pacing is enforced here: a minimum gap between pulses, plus a hold on any cycle where the Reservoir is accepting new input, because a feedback update in that cycle would be overwritten and lost.

---
 rtl/helix_loom_feedback_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/helix_loom_feedback_tx.sv
// helix_loom_feedback_tx: Loom-side feedback transmitter.
// Folds the change between successive observations into a FEEDBACK_W delta,
// queues nonzero deltas and emits them as paced single-cycle pulses that
// avoid cycles in which the Reservoir is accepting new input.

package helix_pkg;
    localparam int CONTEXT_W  = 32;
    localparam int FEEDBACK_W = 8;
endpackage

module helix_loom_feedback_tx #(
    parameter int CONTEXT_W  = helix_pkg::CONTEXT_W,
    parameter int FEEDBACK_W = helix_pkg::FEEDBACK_W,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  obs_valid,
    output logic                  obs_ready,
    input  logic [CONTEXT_W-1:0]  obs_data,
    input  logic                  fb_enable,
    input  logic                  flush,
    input  logic                  rsv_fire,
    output logic                  feedback_valid,
    output logic [FEEDBACK_W-1:0] feedback_delta,
    output logic [15:0]           stat_sent,
    output logic [15:0]           stat_zero
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int GAP_W  = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
    localparam int unsigned NSLICE = CONTEXT_W / FEEDBACK_W;

    logic [FEEDBACK_W-1:0] r_fifo [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [CONTEXT_W-1:0]  r_prev_obs;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [15:0]           r_stat_sent;
    logic [15:0]           r_stat_zero;

    logic [CONTEXT_W-1:0]  w_diff;
    logic [FEEDBACK_W-1:0] w_delta;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_fire;
    logic                  w_push;
    logic                  w_emit;

    // Queue occupancy from wrap-bit pointers
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // Ready is deliberately not bypassed by a same-cycle pop, and is held low in reset
    assign obs_ready = rst_n & ~w_full & ~flush;
    assign w_fire    = obs_valid & obs_ready;
    assign w_push    = w_fire & (w_delta != '0);

    // Emission is suppressed whenever the Reservoir accepts input, since an update that cycle is lost
    assign w_emit         = ~w_empty & fb_enable & (r_gap_cnt == '0) & ~rsv_fire & ~flush;
    assign feedback_valid = w_emit;
    assign feedback_delta = w_emit ? r_fifo[r_rd_ptr[AW-1:0]] : '0;

    assign stat_sent = r_stat_sent;
    assign stat_zero = r_stat_zero;

    // Fold the observation change into one delta by XOR-ing all FEEDBACK_W slices
    always_comb begin
        w_diff  = obs_data ^ r_prev_obs;
        w_delta = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            w_delta = w_delta ^ w_diff[i*FEEDBACK_W +: FEEDBACK_W];
        end
    end

    // Delta storage; validity is tracked entirely by the pointers
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= w_delta;
        end
    end

    // Queue pointers: flush empties, otherwise independent push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_emit) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Previous observation, updated on every accepted observation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_obs <= '0;
        end else if (w_fire) begin
            r_prev_obs <= obs_data;
        end
    end

    // Inter-pulse gap: reloaded on emit, counts down freely otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (flush) begin
            r_gap_cnt <= '0;
        end else if (w_emit) begin
            r_gap_cnt <= GAP_W'(MIN_GAP);
        end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    // Saturating counters for issued pulses and suppressed zero deltas
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_sent <= '0;
            r_stat_zero <= '0;
        end else begin
            if (w_emit && (r_stat_sent != '1)) begin
                r_stat_sent <= r_stat_sent + 1'b1;
            end
            if (w_fire && (w_delta == '0) && (r_stat_zero != '1)) begin
                r_stat_zero <= r_stat_zero + 1'b1;
            end
        end
    end

endmodule
